// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode constants and default datapath width
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_EOR   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_RSB   = 5'b00011;
    localparam logic [4:0] OP_ADD   = 5'b00100;
    localparam logic [4:0] OP_ADC   = 5'b00101;
    localparam logic [4:0] OP_SBC   = 5'b00110;
    localparam logic [4:0] OP_RSC   = 5'b00111;
    localparam logic [4:0] OP_TST   = 5'b01000;
    localparam logic [4:0] OP_TEQ   = 5'b01001;
    localparam logic [4:0] OP_CMP   = 5'b01010;
    localparam logic [4:0] OP_CMN   = 5'b01011;
    localparam logic [4:0] OP_ORR   = 5'b01100;
    localparam logic [4:0] OP_MOV   = 5'b01101;
    localparam logic [4:0] OP_BIC   = 5'b01110;
    localparam logic [4:0] OP_MVN   = 5'b01111;
    localparam logic [4:0] OP_PASSA = 5'b10000;
    localparam logic [4:0] OP_INC4  = 5'b10001;
    localparam logic [4:0] OP_ADD4  = 5'b10010;

    // How the result and C/V flags of an opcode are formed.
    typedef enum logic [1:0] {
        ALU_KIND_ZERO  = 2'd0,
        ALU_KIND_LOGIC = 2'd1,
        ALU_KIND_ARITH = 2'd2
    } alu_kind_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU with Z/N/C/V flags
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [4:0]       i_op,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic             o_z,
    output logic             o_n,
    output logic             o_c,
    output logic             o_v
);

    // Subtractions reuse the adder as x + ~y + carry, so the adder carry-out
    // is directly NOT borrow and the overflow rule is shared with additions.
    alu_kind_e          w_kind;
    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_y;
    logic [2:0]         w_k;
    logic [WIDTH-1:0]   w_logic;
    logic [WIDTH+1:0]   w_sum;
    logic [WIDTH-1:0]   w_res;

    // Decode the opcode into adder operands or a bitwise result.
    always_comb begin
        w_kind  = ALU_KIND_ZERO;
        w_x     = '0;
        w_y     = '0;
        w_k     = 3'd0;
        w_logic = '0;
        case (i_op)
            OP_AND, OP_TST: begin w_kind = ALU_KIND_LOGIC; w_logic = i_a & i_b;  end
            OP_EOR, OP_TEQ: begin w_kind = ALU_KIND_LOGIC; w_logic = i_a ^ i_b;  end
            OP_ORR:         begin w_kind = ALU_KIND_LOGIC; w_logic = i_a | i_b;  end
            OP_MOV:         begin w_kind = ALU_KIND_LOGIC; w_logic = i_b;        end
            OP_BIC:         begin w_kind = ALU_KIND_LOGIC; w_logic = i_a & ~i_b; end
            OP_MVN:         begin w_kind = ALU_KIND_LOGIC; w_logic = ~i_b;       end
            OP_PASSA:       begin w_kind = ALU_KIND_LOGIC; w_logic = i_a;        end
            OP_ADD, OP_CMN: begin w_kind = ALU_KIND_ARITH; w_x = i_a; w_y = i_b; end
            OP_ADC: begin
                w_kind = ALU_KIND_ARITH; w_x = i_a; w_y = i_b; w_k = {2'b00, i_cin};
            end
            OP_INC4: begin
                w_kind = ALU_KIND_ARITH; w_x = i_a; w_y = WIDTH'(4);
            end
            OP_ADD4: begin
                w_kind = ALU_KIND_ARITH; w_x = i_a; w_y = i_b; w_k = 3'd4;
            end
            OP_SUB, OP_CMP: begin
                w_kind = ALU_KIND_ARITH; w_x = i_a; w_y = ~i_b; w_k = 3'd1;
            end
            OP_SBC: begin
                w_kind = ALU_KIND_ARITH; w_x = i_a; w_y = ~i_b; w_k = {2'b00, i_cin};
            end
            OP_RSB: begin
                w_kind = ALU_KIND_ARITH; w_x = i_b; w_y = ~i_a; w_k = 3'd1;
            end
            OP_RSC: begin
                w_kind = ALU_KIND_ARITH; w_x = i_b; w_y = ~i_a; w_k = {2'b00, i_cin};
            end
            default: w_kind = ALU_KIND_ZERO;
        endcase
    end

    // Two guard bits: A+B+4 can exceed 2^(WIDTH+1)-1 only by setting bit WIDTH+1.
    assign w_sum = {2'b00, w_x} + {2'b00, w_y} + (WIDTH+2)'(w_k);

    // Select the result and form the carry/overflow flags by operation class.
    always_comb begin
        w_res = '0;
        o_c   = 1'b0;
        o_v   = 1'b0;
        case (w_kind)
            ALU_KIND_LOGIC: begin
                w_res = w_logic;
                o_c   = i_cin;
            end
            ALU_KIND_ARITH: begin
                w_res = w_sum[WIDTH-1:0];
                o_c   = |w_sum[WIDTH+1:WIDTH];
                o_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_res[WIDTH-1] != w_x[WIDTH-1]);
            end
            default: w_res = '0;
        endcase
    end

    assign o_result = w_res;
    assign o_z      = (w_res == '0);
    assign o_n      = w_res[WIDTH-1];

endmodule

// File: rtl/alu_ir_mar_unit.sv
// rtl/alu_ir_mar_unit.sv - ALU with instruction register and memory address register
module alu_ir_mar_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             IRLd,
    input  logic             MARLd,
    input  logic [WIDTH-1:0] DataIn,
    input  logic [WIDTH-1:0] PA,
    input  logic [WIDTH-1:0] PB,
    input  logic [4:0]       OP,
    input  logic             Cin,
    output logic [WIDTH-1:0] Result,
    output logic             FlagZ,
    output logic             FlagN,
    output logic             FlagC,
    output logic             FlagV,
    output logic [WIDTH-1:0] IROut,
    output logic [WIDTH-1:0] MAROut
);

    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_mar;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .i_a      (PA),
        .i_b      (PB),
        .i_op     (OP),
        .i_cin    (Cin),
        .o_result (w_result),
        .o_z      (FlagZ),
        .o_n      (FlagN),
        .o_c      (FlagC),
        .o_v      (FlagV)
    );

    // IR captures memory data, MAR captures the ALU result; reset wins over both loads.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_ir  <= '0;
            r_mar <= '0;
        end else begin
            if (IRLd)  r_ir  <= DataIn;
            if (MARLd) r_mar <= w_result;
        end
    end

    assign Result = w_result;
    assign IROut  = r_ir;
    assign MAROut = r_mar;

endmodule

// File: tb/tb_alu_ir_mar_unit.sv
// tb/tb_alu_ir_mar_unit.sv - randomized self-checking bench for alu_ir_mar_unit
module tb_alu_ir_mar_unit;

    logic        CLK = 1'b0;
    logic        CLR, IRLd, MARLd, Cin;
    logic [31:0] DataIn, PA, PB;
    logic [4:0]  OP;
    logic [31:0] Result, IROut, MAROut;
    logic        FlagZ, FlagN, FlagC, FlagV;

    int n_vec = 0;
    int n_err = 0;

    logic        chk_en    = 1'b0;
    logic        reg_valid = 1'b0;
    logic [31:0] exp_ir, exp_mar;

    alu_ir_mar_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .CLR(CLR), .IRLd(IRLd), .MARLd(MARLd), .DataIn(DataIn),
        .PA(PA), .PB(PB), .OP(OP), .Cin(Cin), .Result(Result),
        .FlagZ(FlagZ), .FlagN(FlagN), .FlagC(FlagC), .FlagV(FlagV),
        .IROut(IROut), .MAROut(MAROut)
    );

    always #5 CLK = ~CLK;

    // Reference: plain 64-bit arithmetic straight from the opcode table.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, output logic [31:0] r, output logic c, output logic v);
        logic [63:0] s64;
        longint      d;
        logic [31:0] m, s, y;
        int          k;
        int          cls;   // 0 zero, 1 logical, 2 add, 3 subtract
        r = 32'h0; c = 1'b0; v = 1'b0; cls = 0; m = 32'h0; s = 32'h0; y = 32'h0; k = 0;
        case (op)
            5'd0, 5'd8:  begin cls = 1; r = a & b;  end
            5'd1, 5'd9:  begin cls = 1; r = a ^ b;  end
            5'd12:       begin cls = 1; r = a | b;  end
            5'd13:       begin cls = 1; r = b;      end
            5'd14:       begin cls = 1; r = a & ~b; end
            5'd15:       begin cls = 1; r = ~b;     end
            5'd16:       begin cls = 1; r = a;      end
            5'd4, 5'd11: begin cls = 2; y = b; k = 0; end
            5'd5:        begin cls = 2; y = b; k = int'(cin); end
            5'd17:       begin cls = 2; y = 32'd4; k = 0; end
            5'd18:       begin cls = 2; y = b; k = 4; end
            5'd2, 5'd10: begin cls = 3; m = a; s = b; k = 0; end
            5'd6:        begin cls = 3; m = a; s = b; k = int'(!cin); end
            5'd3:        begin cls = 3; m = b; s = a; k = 0; end
            5'd7:        begin cls = 3; m = b; s = a; k = int'(!cin); end
            default:     cls = 0;
        endcase
        if (cls == 1) begin
            c = cin;
        end else if (cls == 2) begin
            s64 = {32'h0, a} + {32'h0, y} + 64'(k);
            r = s64[31:0];
            c = (s64 >= 64'h1_0000_0000);
            v = (a[31] == y[31]) && (r[31] != a[31]);
        end else if (cls == 3) begin
            d = longint'({32'h0, m}) - longint'({32'h0, s}) - longint'(k);
            r = d[31:0];
            c = (d >= 0);
            v = (m[31] != s[31]) && (r[31] != m[31]);
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 8));
            default: return $urandom;
        endcase
    endfunction

    // Register model: updates at the same edge the DUT samples its inputs.
    always @(posedge CLK) begin
        logic [31:0] r;
        logic        c, v;
        model(OP, PA, PB, Cin, r, c, v);
        if (CLR) begin
            exp_ir    <= 32'h0;
            exp_mar   <= 32'h0;
            reg_valid <= 1'b1;
        end else begin
            if (IRLd)  exp_ir  <= DataIn;
            if (MARLd) exp_mar <= r;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge CLK) begin
        logic [31:0] r;
        logic        c, v;
        if (chk_en) begin
            model(OP, PA, PB, Cin, r, c, v);
            chk("result", Result, r);
            chk("flag_z", 32'(FlagZ), 32'(r == 32'h0));
            chk("flag_n", 32'(FlagN), 32'(r[31]));
            chk("flag_c", 32'(FlagC), 32'(c));
            chk("flag_v", 32'(FlagV), 32'(v));
            if (reg_valid) begin
                chk("ir", IROut, exp_ir);
                chk("mar", MAROut, exp_mar);
            end
        end
    end

    task automatic alu_lit(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic cin, input logic [31:0] er,
                           input logic ez, input logic en, input logic ec, input logic ev);
        @(posedge CLK); #1;
        IRLd = 1'b0; MARLd = 1'b0; CLR = 1'b0;
        OP = op; PA = a; PB = b; Cin = cin;
        #1;
        chk({name, "_res"}, Result, er);
        chk({name, "_z"}, 32'(FlagZ), 32'(ez));
        chk({name, "_n"}, 32'(FlagN), 32'(en));
        chk({name, "_c"}, 32'(FlagC), 32'(ec));
        chk({name, "_v"}, 32'(FlagV), 32'(ev));
    endtask

    initial begin
        CLR = 1'b1; IRLd = 1'b1; MARLd = 1'b1; Cin = 1'b0;
        DataIn = 32'hDEAD_BEEF; PA = 32'h0; PB = 32'h0; OP = 5'd4;
        @(posedge CLK); #1;
        chk("reset_ir", IROut, 32'h0);
        chk("reset_mar", MAROut, 32'h0);
        chk_en = 1'b1;
        CLR = 1'b0; IRLd = 1'b0; MARLd = 1'b0;

        alu_lit("add_ovf",  5'd4,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 0, 1, 0, 1);
        alu_lit("sub_eq",   5'd2,  32'd5,         32'd5,         1'b0, 32'h0000_0000, 1, 0, 1, 0);
        alu_lit("sub_neg",  5'd2,  32'd3,         32'd5,         1'b0, 32'hFFFF_FFFE, 0, 1, 0, 0);
        alu_lit("adc_wrap", 5'd5,  32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0000_0000, 1, 0, 1, 0);
        alu_lit("add4_top", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0002, 0, 0, 1, 1);
        alu_lit("rsc_brw",  5'd7,  32'd1,         32'd1,         1'b0, 32'hFFFF_FFFF, 0, 1, 0, 0);
        alu_lit("mvn_cin",  5'd15, 32'h1234_5678, 32'h0,         1'b1, 32'hFFFF_FFFF, 0, 1, 1, 0);
        alu_lit("unused",   5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1, 0, 0, 0);

        // MAR captures INC4 result, then holds while PA moves.
        @(posedge CLK); #1;
        OP = 5'd17; PA = 32'h100; PB = 32'h0; Cin = 1'b0; MARLd = 1'b1;
        @(posedge CLK); #1;
        chk("mar_inc4", MAROut, 32'h104);
        MARLd = 1'b0; PA = 32'h5555_0000;
        @(posedge CLK); #1;
        chk("mar_hold", MAROut, 32'h104);

        // IR load, then reset overriding both load enables.
        IRLd = 1'b1; DataIn = 32'hE3A0_1005;
        @(posedge CLK); #1;
        chk("ir_load", IROut, 32'hE3A0_1005);
        CLR = 1'b1; IRLd = 1'b1; MARLd = 1'b1; DataIn = 32'h1111_2222;
        @(posedge CLK); #1;
        chk("clr_ir", IROut, 32'h0);
        chk("clr_mar", MAROut, 32'h0);
        CLR = 1'b0; IRLd = 1'b0; MARLd = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            @(posedge CLK); #1;
            CLR    = ($urandom_range(0, 31) == 0);
            IRLd   = $urandom_range(0, 1) != 0;
            MARLd  = $urandom_range(0, 1) != 0;
            DataIn = $urandom;
            PA     = pick();
            PB     = pick();
            OP     = 5'($urandom_range(0, 31));
            Cin    = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 3) == 0) begin
                #2;
                DataIn = $urandom;
                PA     = pick();
            end
        end

        @(negedge CLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
